// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes, FSM states.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // Single-pass ALU opcodes
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;

  // Single-bit shift/rotate opcodes, iterated by the sequencer
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_classify.sv
// Combinational opcode decode: which opcodes the ALU supports, and which iterate.
module alu_op_classify
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output logic       is_valid,
  output logic       is_shift
);

  // Decode opcode into supported / shift-class flags
  always_comb begin
    is_valid = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: is_valid = 1'b1;
      OP_ASR, OP_SLL, OP_SRL, OP_ROL, OP_ROR: begin
        is_valid = 1'b1;
        is_shift = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the clocked ALU. Multi-bit shifts/rotates are built
// by reissuing the single-bit op, feeding each ALU result back as operand A.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [SHAMT_W-1:0]  cmd_shamt,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_op,
  output logic                alu_enable,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_zero,
  output logic                rsp_err
);

  state_t               state, next_state;
  logic [SHAMT_W-1:0]   remaining;
  logic                 is_valid, is_shift;
  logic                 cmd_fire, direct_resp;

  alu_op_classify u_classify (
    .op       (cmd_op),
    .is_valid (is_valid),
    .is_shift (is_shift)
  );

  // Held low during reset so no command is advertised until reset is released
  assign cmd_ready   = (state == ST_IDLE) && !reset;
  assign cmd_fire    = cmd_valid && cmd_ready;
  // Commands answered without touching the ALU
  assign direct_resp = !is_valid || (is_shift && (cmd_shamt == '0));
  assign alu_enable  = (state == ST_ISSUE);
  assign rsp_valid   = (state == ST_RESP);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (cmd_fire) next_state = direct_resp ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = (remaining == SHAMT_W'(1)) ? ST_RESP : ST_ISSUE;
      ST_RESP:    if (rsp_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // ALU drive registers, iteration count and response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      remaining <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (!is_valid) begin
              rsp_data <= '0;
              rsp_zero <= 1'b0;
              rsp_err  <= 1'b1;
            end else if (is_shift && (cmd_shamt == '0)) begin
              rsp_data <= cmd_a;
              rsp_zero <= (cmd_a == '0);
              rsp_err  <= 1'b0;
            end else begin
              alu_a     <= cmd_a;
              alu_b     <= is_shift ? '0 : cmd_b;
              alu_op    <= cmd_op;
              remaining <= is_shift ? cmd_shamt : SHAMT_W'(1);
            end
          end
        end
        ST_CAPTURE: begin
          remaining <= remaining - SHAMT_W'(1);
          if (remaining == SHAMT_W'(1)) begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            // Feed the partial result back; alu_a only moves before a reissue
            alu_a <= alu_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a registered ALU stand-in.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [4:0]  cmd_shamt;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_enable;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;

  int checks = 0;
  int fails  = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the clocked ALU: one single-bit step per enable
  function automatic logic [31:0] alu_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_NOT: return ~a;
      OP_ASR: return {a[31], a[31:1]};
      OP_SLL: return {a[30:0], 1'b0};
      OP_SRL: return {1'b0, a[31:1]};
      OP_ROL: return {a[30:0], a[31]};
      OP_ROR: return {a[0], a[31:1]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_enable) begin
      alu_out  <= alu_step(alu_op, alu_a, alu_b);
      alu_zero <= (alu_step(alu_op, alu_a, alu_b) == 32'h0);
    end
  end

  // Reference model: whole-amount shifts in closed form
  function automatic logic [31:0] shift_k(input logic [3:0] op, input logic [31:0] a, input int k);
    if (k == 0) return a;
    case (op)
      OP_ASR: return 32'($signed(a) >>> k);
      OP_SLL: return a << k;
      OP_SRL: return a >> k;
      OP_ROL: return (a << k) | (a >> (32 - k));
      OP_ROR: return (a >> k) | (a << (32 - k));
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit op_valid(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                      4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
  endfunction

  function automatic logic [31:0] single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command, follow it to completion and check every cycle on the way
  task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int hold,
                         input bit use_lit, input logic [31:0] lit);
    bit          v, s;
    logic [31:0] exp_d, d0;
    logic        exp_z, exp_e, z0, e0;
    int          exp_lat, exp_en, cyc, en, tmo;
    v = op_valid(op);
    s = v && op[3];
    if (!v) begin
      exp_d = 32'h0; exp_z = 1'b0; exp_e = 1'b1; exp_lat = 1; exp_en = 0;
    end else if (s) begin
      exp_d = shift_k(op, a, int'(sh)); exp_z = (exp_d == 32'h0); exp_e = 1'b0;
      exp_lat = 2 * int'(sh) + 1; exp_en = int'(sh);
    end else begin
      exp_d = single(op, a, b); exp_z = (exp_d == 32'h0); exp_e = 1'b0;
      exp_lat = 3; exp_en = 1;
    end
    tmo = 0;
    while (!cmd_ready && tmo < 50) begin @(negedge clk); tmo++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom; cmd_shamt = 5'($urandom);
    cyc = 1; en = 0;
    while (!rsp_valid && cyc < 100) begin
      chk("cmd_ready_busy", cmd_ready, 0);
      if (alu_enable) begin
        chk("enable_spacing", cyc % 2, 1);
        chk("alu_a", alu_a, s ? shift_k(op, a, en) : a);
        chk("alu_b", alu_b, s ? 32'h0 : b);
        chk("alu_op", alu_op, op);
        en++;
      end
      @(negedge clk); cyc++;
    end
    chk("latency", cyc, exp_lat);
    chk("enable_count", en, exp_en);
    chk("rsp_enable_low", alu_enable, 0);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_zero", rsp_zero, exp_z);
    chk("rsp_err", rsp_err, exp_e);
    if (use_lit) chk("rsp_data_literal", rsp_data, lit);
    d0 = rsp_data; z0 = rsp_zero; e0 = rsp_err;
    repeat (hold) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, d0);
      chk("bp_flags", {30'h0, rsp_zero, rsp_err}, {30'h0, z0, e0});
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_enable", alu_enable, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_dropped", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_shamt = '0;
    rsp_ready = 1'b0; alu_out = '0; alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, alu_enable, rsp_valid, rsp_zero, rsp_err}, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_rsp_data", rsp_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    // Pin the closed-form model against hand-computed values
    chk("model_rol4", shift_k(OP_ROL, 32'h8000_0001, 4), 32'h0000_0018);
    chk("model_asr31", shift_k(OP_ASR, 32'h8000_0000, 31), 32'hFFFF_FFFF);
    chk("model_ror1", shift_k(OP_ROR, 32'h0000_0001, 1), 32'h8000_0000);

    run_cmd(OP_ADD, 32'h5, 32'h7, 5'd0, 0, 1, 32'h0000_000C);
    run_cmd(OP_SUB, 32'h1234_5678, 32'h1234_5678, 5'd3, 0, 1, 32'h0);
    run_cmd(OP_SUB, 32'h0, 32'h1, 5'd0, 10, 1, 32'hFFFF_FFFF);
    run_cmd(OP_ROL, 32'h8000_0001, 32'hABCD_0000, 5'd4, 0, 1, 32'h0000_0018);
    run_cmd(OP_ASR, 32'h8000_0000, 32'h0, 5'd31, 0, 1, 32'hFFFF_FFFF);
    run_cmd(OP_SLL, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, 1, 32'hDEAD_BEEF);
    run_cmd(4'b0111, 32'h1111_1111, 32'h2, 5'd5, 2, 1, 32'h0);
    run_cmd(OP_NOT, 32'hFFFF_FFFF, 32'h5555_5555, 5'd0, 1, 1, 32'h0);

    // Reset in CAPTURE of an 8-step shift
    cmd_valid = 1'b1; cmd_op = OP_SRL; cmd_a = 32'hF000_0000; cmd_b = 32'h0; cmd_shamt = 5'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_issue", alu_enable, 1);
    @(negedge clk);
    chk("rst_capture", alu_enable, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_enable", alu_enable, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_again", cmd_ready, 1);
    chk("rst_no_resp", rsp_valid, 0);
    run_cmd(OP_OR, 32'h0F00_0000, 32'h0000_00F0, 5'd0, 0, 1, 32'h0F00_00F0);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      run_cmd(rop, ra, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3), 0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
